tmds_transmitter: RTL
=====================

# tmds_transmitter

- Takes the per-pixel timing from `video_sync` (`blanking`, `h_sync`, `v_sync`, `pixel_clk`) and 8-bit RGB from the pixel generator.
- Produces three DVI 1.0 TMDS data lanes and the TMDS clock lane as single-bit streams at the `clk` rate (10× pixel rate).
- Sits between `video_sync`/pixel source and the board's differential output buffers.
- Encoding is TMDS 8b/10b with running-disparity DC balance; serialization is LSB first.

## Interface

Parameters:
- `INVERT_SYNC`, default 1: when 1, encoded C0/C1 = ~`h_sync`/~`v_sync` (negative-sync modes such as 640x480); when 0, passed as-is.

Ports:
- `clk`  in  1  bit clock, 10× pixel rate.
- `rst`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `pixel_clk`  in  1  divided pixel clock from `video_sync` (nominally 5 high / 5 low `clk` cycles).
- `blanking`  in  1  high = control period, low = video data.
- `h_sync`  in  1  horizontal sync, active-high as produced by `video_sync`.
- `v_sync`  in  1  vertical sync, active-high.
- `red`, `green`, `blue`  in  8 each  pixel colour.
- `tmds_d`  out  3  serial bits; [0]=blue, [1]=green, [2]=red.
- `tmds_clk`  out  1  TMDS clock lane.

## Operation

- **Load strobe:** `pc_q` registers `pixel_clk`. `load = pixel_clk & ~pc_q` (rising edge). All pixel-rate actions happen only on `load` cycles.
- **On `load`, per lane:**
  - The shift register takes the held symbol register.
  - The symbol register takes the newly encoded symbol from the current inputs.
  - This gives a one-pixel pipeline.
- **Not on `load`:** shift register shifts right one bit, filling with 0. `tmds_d[i]` = shift register bit 0.
- **Control period (`blanking`=1):**
  - Token by {C1,C0}: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - Disparity counter is cleared to 0.
  - Blue lane: C0 = hsync, C1 = vsync (after `INVERT_SYNC`). Green/red lanes: C1:C0 = 00.
- **Data period (DVI 1.0 algorithm):**
  - n1(d) = ones in d. Use the XNOR chain if n1(d)>4, or if n1(d)==4 and d[0]==0; otherwise use the XOR chain.
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Disparity `cnt` is 5-bit signed, range ±10 even values. n0/n1 count q_m[7:0].
  - **Case cnt==0 or n1==n0:**
    - q_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? n1−n0 : n0−n1.
  - **Case (cnt>0 & n1>n0) | (cnt<0 & n0>n1):**
    - q_out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + n0 − n1.
  - **Otherwise:**
    - q_out = {0, q_m[8], q_m[7:0]}.
    - cnt −= 2·~q_m[8]; cnt += n1 − n0.
  - `cnt` updates only on `load`.
- **`tmds_clk`:** `pixel_clk` delayed one cycle (equals `pc_q`), so its rising edge coincides with bit 0 of each word.
- **Irregular `pixel_clk`:**
  - An edge arriving fewer than 10 cycles after the previous one reloads early; the old word is truncated.
  - More than 10 cycles: trailing zeros are emitted.
  - No error flag.
- **Reset values (`rst`=0, immediately, no clock needed):**
  - `pc_q`=0, shift registers=0, `tmds_d`=000, `tmds_clk`=0, `cnt`=0.
  - Symbol registers = 10'b1101010100.
  - Mid-word reset discards the word. The first `load` after release emits the reset token.

## Timing

- Inputs are sampled only on `load` cycles; setup relative to `clk`.
- The pixel sampled at load N is serialized in the 10 `clk` cycles following load N+1.
  - Bit 0 appears on `tmds_d` in the cycle after load N+1.
  - Bit 9 appears 9 cycles later.
- `tmds_clk` is high for 5 cycles then low for 5, rising in the same cycle as bit 0.
- All outputs are registered; no combinational input→output path.

## Structure

- Package `tmds_pkg`:
  - Four control token constants.
  - Symbol width 10.
  - Disparity width 5.
  - Lane index constants.
- Sub-module `tmds_encoder` (clk, rst, load, de, c[1:0], d[7:0] → q[9:0]):
  - Owns `cnt` and the symbol register.
  - Instantiated three times.
- Top-level owns: edge detect, sync inversion, three 10-bit shift registers, `tmds_clk` register.

## Test plan

- **Reset:**
  - Hold `rst`=0 mid-word → `tmds_d`=000, `tmds_clk`=0 without a `clk` edge.
  - After release with `blanking`=1, `h_sync`=`v_sync`=0, `INVERT_SYNC`=1: first word 1101010100 on all lanes, then blue 1010101011, green/red 1101010100, LSB first.
- **Data 0x00 ×3 on blue after blanking:** symbols 0x100, 0x3FF, 0x100; `cnt` −8, +2, −6.
- **Data 0xFF after blanking:** symbol 0x200; `cnt` −8.
- **Blanking clears disparity:** data 0x00, then one blanked pixel, then 0x00 → second data symbol is 0x100 (not 0x3FF).
- **Alignment:**
  - Drive distinct known pixels P0, P1, P2 with a 10-cycle `pixel_clk`.
  - P0 bit 0 appears the cycle after the second `load`.
  - `tmds_clk` rises in that same cycle and stays high exactly 5 cycles.
- **Sync tokens, `INVERT_SYNC`=0:** `blanking`=1, `h_sync`=1, `v_sync`=0 → blue 0010101011, green/red 1101010100.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS transmitter: control tokens,
// symbol/disparity widths, lane indices.
package tmds_pkg;

  localparam int unsigned SYM_W     = 10;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_LANES = 3;

  localparam int unsigned LANE_BLUE  = 0;
  localparam int unsigned LANE_GREEN = 1;
  localparam int unsigned LANE_RED   = 2;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(DATA_W); i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] t;
    t = CTRL_00;
    case (c)
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      2'b11:   t = CTRL_11;
      default: t = CTRL_00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One TMDS lane: 8b/10b encode with running disparity, held in a symbol
// register that advances only on the pixel-rate load strobe.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              de,
  input  logic [1:0]        c,
  input  logic [DATA_W-1:0] d,
  output logic [SYM_W-1:0]  q
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] diff;
  logic [SYM_W-1:0]        sym_nxt;
  logic [8:0]              q_m;
  logic [3:0]              n1_d;
  logic [3:0]              n1_q;
  logic [3:0]              n0_q;
  logic                    use_xnor;

  // Transition-minimising stage followed by DC-balance stage
  always_comb begin
    n1_d     = popcount8(d);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    q_m      = '0;
    q_m[0]   = d[0];
    for (int i = 1; i < int'(DATA_W); i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
    q_m[8]   = ~use_xnor;
    n1_q     = popcount8(q_m[7:0]);
    n0_q     = 4'd8 - n1_q;
    diff     = $signed(CNT_W'(n1_q)) - $signed(CNT_W'(n0_q));
    sym_nxt  = ctrl_token(c);
    cnt_nxt  = '0;
    if (de) begin
      if ((cnt == '0) || (n1_q == n0_q)) begin
        sym_nxt = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_nxt = q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[CNT_W-1] && (n1_q > n0_q)) || (cnt[CNT_W-1] && (n0_q > n1_q))) begin
        sym_nxt = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_nxt = q_m[8] ? (cnt + TWO - diff) : (cnt - diff);
      end else begin
        sym_nxt = {1'b0, q_m[8], q_m[7:0]};
        cnt_nxt = q_m[8] ? (cnt + diff) : (cnt - TWO + diff);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      q   <= CTRL_00;
    end else if (load) begin
      cnt <= cnt_nxt;
      q   <= sym_nxt;
    end
  end

endmodule

// File: rtl/tmds_transmitter.sv
// DVI TMDS transmitter: pixel-clock edge detect, three lane encoders and
// LSB-first serialisers, plus the TMDS clock lane.
module tmds_transmitter
  import tmds_pkg::*;
#(
  parameter bit INVERT_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_clk,
  input  logic              blanking,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic [2:0]        tmds_d,
  output logic              tmds_clk
);

  logic                    pc_q;
  logic                    load_c;
  logic [DATA_W-1:0]       lane_d [NUM_LANES];
  logic [1:0]              lane_c [NUM_LANES];
  logic [SYM_W-1:0]        sym    [NUM_LANES];
  logic [SYM_W-1:0]        shift  [NUM_LANES];

  assign load_c = pixel_clk & ~pc_q;

  // Sync rides on the blue lane only
  always_comb begin
    lane_d[LANE_BLUE]  = blue;
    lane_d[LANE_GREEN] = green;
    lane_d[LANE_RED]   = red;
    lane_c[LANE_BLUE]  = INVERT_SYNC ? {~v_sync, ~h_sync} : {v_sync, h_sync};
    lane_c[LANE_GREEN] = 2'b00;
    lane_c[LANE_RED]   = 2'b00;
  end

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    tmds_encoder u_enc (
      .clk  (clk),
      .rst  (rst),
      .load (load_c),
      .de   (~blanking),
      .c    (lane_c[g]),
      .d    (lane_d[g]),
      .q    (sym[g])
    );
    assign tmds_d[g] = shift[g][0];
  end

  // Serialisers take the previously held symbol, giving a one-pixel pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= 1'b0;
      for (int i = 0; i < int'(NUM_LANES); i++) shift[i] <= '0;
    end else begin
      pc_q <= pixel_clk;
      for (int i = 0; i < int'(NUM_LANES); i++)
        shift[i] <= load_c ? sym[i] : (shift[i] >> 1);
    end
  end

  assign tmds_clk = pc_q;

endmodule
